debug_hex_monitor: RTL and testbench

DEBUG_HEX_MONITOR -- requirements
Module: debug_hex_monitor

---
 rtl/debug_hex_monitor_pkg.sv | 13 +
 rtl/debug_hex_monitor_if.sv | 11 +
 rtl/debug_hex_monitor_key.sv | 31 +++
 rtl/debug_hex_monitor.sv | 58 +++++
 tb/tb_debug_hex_monitor.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/debug_hex_monitor_pkg.sv
// debug_hex_monitor_pkg: shared seven-segment glyph table and counter-width helper for display blocks
package debug_hex_monitor_pkg;
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] seg7(input logic [3:0] n);
    return SEG_TAB[n];
  endfunction
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debug_hex_monitor_if.sv
// debug_hex_monitor_if: probe/key/mode inputs and hex/ch_sel/press_pulse outputs; master drives inputs, slave is the monitor
interface debug_hex_monitor_if #(parameter int NUM_CH = 4);
  logic [NUM_CH*32-1:0] probe;
  logic key_next_n, auto_scan, freeze, press_pulse;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [3:0] ch_sel;
  modport master (output probe, key_next_n, auto_scan, freeze,
                  input hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, ch_sel, press_pulse);
  modport slave  (input probe, key_next_n, auto_scan, freeze,
                  output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, ch_sel, press_pulse);
endinterface

// File: rtl/debug_hex_monitor_key.sv
// key_debounce: 2-flop sync + debounce of active-low key_n (CLOCK_50, rst in); press = one-cycle strobe on accepted press
module key_debounce
  import debug_hex_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int W = cnt_w(DEBOUNCE_CYC);
  logic s1, s2, level, hit;
  logic [W-1:0] cnt;
  assign hit = (s2 != level) && (cnt == W'(DEBOUNCE_CYC - 1));
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      cnt   <= (s2 == level || hit) ? '0 : cnt + 1'b1;
      level <= hit ? s2 : level;
      press <= hit && !s2;
    end
  end
endmodule

// File: rtl/debug_hex_monitor.sv
// debug_hex_monitor: hex display of a selected 32-bit probe channel (CLOCK_50, rst, bus.slave: probe/key/auto_scan/freeze in, hex0..7/ch_sel/press_pulse out)
module debug_hex_monitor
  import debug_hex_monitor_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SCAN_CYC     = 100000000
) (
  input  logic CLOCK_50,
  input  logic rst,
  debug_hex_monitor_if.slave bus
);
  localparam int SW = cnt_w(SCAN_CYC);
  logic press, expire, adv, chg;
  logic [SW-1:0] scan;
  logic [3:0] ch;
  logic [31:0] word, snap;
  logic [7:0][6:0] hx;
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .CLOCK_50(CLOCK_50),
    .rst(rst),
    .key_n(bus.key_next_n),
    .press(press)
  );
  assign expire = bus.auto_scan && scan == SW'(SCAN_CYC - 1);
  assign adv = press || expire;
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch == 4'(k)) word = bus.probe[32*k +: 32];
  end
  // chg marks the cycle after a channel change so a frozen display still picks up the new channel once
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      scan <= '0;
      ch   <= '0;
      chg  <= 1'b0;
      snap <= '0;
      hx   <= {8{seg7(4'h0)}};
    end else begin
      scan <= (!bus.auto_scan || adv) ? '0 : scan + 1'b1;
      ch   <= adv ? (ch == 4'(NUM_CH - 1) ? '0 : ch + 1'b1) : ch;
      chg  <= adv;
      snap <= (!bus.freeze || chg) ? word : snap;
      for (int i = 0; i < 8; i++) hx[i] <= seg7(snap[4*i +: 4]);
    end
  end
  assign bus.hex0 = hx[0];
  assign bus.hex1 = hx[1];
  assign bus.hex2 = hx[2];
  assign bus.hex3 = hx[3];
  assign bus.hex4 = hx[4];
  assign bus.hex5 = hx[5];
  assign bus.hex6 = hx[6];
  assign bus.hex7 = hx[7];
  assign bus.ch_sel = ch;
  assign bus.press_pulse = press;
endmodule

// File: tb/tb_debug_hex_monitor.sv
// tb_debug_hex_monitor: randomized self-checking bench with a behavioural display-monitor model
module tb_debug_hex_monitor;
  localparam int N = 3, D = 4, S = 10;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  debug_hex_monitor_if #(.NUM_CH(N)) bus();
  debug_hex_monitor #(.NUM_CH(N), .DEBOUNCE_CYC(D), .SCAN_CYC(S)) dut (
    .CLOCK_50(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [55:0] hex_all;
  assign hex_all = {bus.hex7, bus.hex6, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  int nvec = 0, nerr = 0;
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  bit kq[$];
  bit m_level, m_press;
  int m_run, m_age, m_ch, m_ch_old;
  logic [31:0] m_snap;
  logic [55:0] m_hex;

  function automatic logic [6:0] glyph(input int n);
    logic [6:0] s;
    s = 7'h7F;
    for (int i = 0; i < lit[n].len(); i++) s[int'(lit[n][i]) - 97] = 1'b0;
    return s;
  endfunction

  function automatic logic [55:0] hex_of(input logic [31:0] w);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = glyph(int'(w[4*i +: 4]));
    return r;
  endfunction

  task automatic step();
    bit seen, adv;
    @(posedge clk);
    if (rst) begin
      kq.delete();
      kq.push_back(1'b1);
      kq.push_back(1'b1);
      m_level = 1; m_press = 0; m_run = 0; m_age = 0; m_ch = 0; m_ch_old = 0;
      m_snap = 0; m_hex = hex_of(32'h0);
    end else begin
      seen = kq.pop_front();
      kq.push_back(bus.key_next_n);
      adv = m_press || (bus.auto_scan && m_age == S - 1);
      m_age = (!bus.auto_scan || adv) ? 0 : m_age + 1;
      m_hex = hex_of(m_snap);
      if (!bus.freeze || m_ch != m_ch_old) m_snap = bus.probe[32*m_ch +: 32];
      m_ch_old = m_ch;
      if (adv) m_ch = (m_ch + 1) % N;
      m_press = 0;
      if (seen == m_level) m_run = 0;
      else if (++m_run == D) begin
        m_level = seen;
        m_run = 0;
        m_press = !seen;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    bus.key_next_n = 1; bus.auto_scan = 0; bus.freeze = 0;
    bus.probe = {$urandom, $urandom, $urandom};
    do_reset();
    nvec++; if (bus.ch_sel !== 4'd0) begin nerr++; $display("FAIL reset ch_sel: got %0d want 0", bus.ch_sel); end
    nvec++; if (hex_all !== {8{7'h40}}) begin nerr++; $display("FAIL reset hex: got %h want %h", hex_all, {8{7'h40}}); end
    nvec++; if (bus.press_pulse !== 1'b0) begin nerr++; $display("FAIL reset press_pulse: got %b want 0", bus.press_pulse); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      bus.key_next_n = i >= 30 ? 1'b1 : i >= 20 ? 1'b0 : ((i / 2) % 2 == 0 ? 1'b0 : 1'b1);
      step();
      if (bus.press_pulse === 1'b1) pulses++;
      nvec++; if (bus.press_pulse !== m_press) begin nerr++; $display("FAIL bounce press_pulse @%0d: got %b want %b", i, bus.press_pulse, m_press); end
      nvec++; if (bus.ch_sel !== 4'(m_ch)) begin nerr++; $display("FAIL bounce ch_sel @%0d: got %0d want %0d", i, bus.ch_sel, m_ch); end
    end
    nvec++; if (pulses != 1) begin nerr++; $display("FAIL bounce pulse count: got %0d want 1", pulses); end
    nvec++; if (bus.ch_sel !== 4'd1) begin nerr++; $display("FAIL bounce final ch_sel: got %0d want 1", bus.ch_sel); end
  endtask

  task automatic test_wrap();
    bus.probe = {32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        bus.key_next_n = i >= 8;
        step();
        nvec++; if (bus.ch_sel !== 4'(m_ch)) begin nerr++; $display("FAIL wrap ch_sel p%0d @%0d: got %0d want %0d", p, i, bus.ch_sel, m_ch); end
        nvec++; if (hex_all !== m_hex) begin nerr++; $display("FAIL wrap hex p%0d @%0d: got %h want %h", p, i, hex_all, m_hex); end
      end
      nvec++; if (bus.ch_sel !== 4'((p + 1) % 3)) begin nerr++; $display("FAIL wrap step ch_sel: got %0d want %0d", bus.ch_sel, (p + 1) % 3); end
    end
    nvec++; if (hex_all !== hex_of(32'hDEADBEEF)) begin nerr++; $display("FAIL wrap DEADBEEF hex: got %h want %h", hex_all, hex_of(32'hDEADBEEF)); end
  endtask

  task automatic test_auto_scan();
    int changes[$];
    int prev;
    int want[5] = '{10, 20, 30, 40, 50};
    bus.probe = {$urandom, $urandom, $urandom};
    bus.key_next_n = 1;
    do_reset();
    bus.auto_scan = 1;
    prev = 0;
    for (int i = 1; i <= 52; i++) begin
      bus.key_next_n = !(i >= 34 && i < 42);
      step();
      if (bus.ch_sel !== 4'(prev)) changes.push_back(i);
      prev = int'(bus.ch_sel);
      nvec++; if (bus.ch_sel !== 4'(m_ch)) begin nerr++; $display("FAIL auto ch_sel @%0d: got %0d want %0d", i, bus.ch_sel, m_ch); end
      nvec++; if (bus.press_pulse !== m_press) begin nerr++; $display("FAIL auto press_pulse @%0d: got %b want %b", i, bus.press_pulse, m_press); end
      if (i == 39) begin
        nvec++; if (bus.press_pulse !== 1'b1) begin nerr++; $display("FAIL auto collision press: got %b want 1", bus.press_pulse); end
      end
    end
    nvec++; if (changes.size() != 5) begin nerr++; $display("FAIL auto advance count: got %0d want 5", changes.size()); end
    for (int k = 0; k < 5 && k < changes.size(); k++) begin
      nvec++; if (changes[k] != want[k]) begin nerr++; $display("FAIL auto advance cycle %0d: got %0d want %0d", k, changes[k], want[k]); end
    end
    bus.auto_scan = 0;
  endtask

  task automatic test_freeze();
    logic [55:0] all_f;
    all_f = {8{7'h0E}};
    bus.probe = {$urandom, $urandom, 32'h0};
    do_reset();
    for (int i = 0; i < 3; i++) step();
    bus.freeze = 1;
    bus.probe[31:0] = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) step();
    nvec++; if (hex_all !== {8{7'h40}}) begin nerr++; $display("FAIL freeze hold hex: got %h want %h", hex_all, {8{7'h40}}); end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        bus.key_next_n = i >= 8;
        step();
        nvec++; if (hex_all !== m_hex) begin nerr++; $display("FAIL freeze hex p%0d @%0d: got %h want %h", p, i, hex_all, m_hex); end
        nvec++; if (bus.ch_sel !== 4'(m_ch)) begin nerr++; $display("FAIL freeze ch_sel p%0d @%0d: got %0d want %0d", p, i, bus.ch_sel, m_ch); end
      end
    nvec++; if (bus.ch_sel !== 4'd0) begin nerr++; $display("FAIL freeze wrap ch_sel: got %0d want 0", bus.ch_sel); end
    nvec++; if (hex_all !== all_f) begin nerr++; $display("FAIL freeze reload hex: got %h want %h", hex_all, all_f); end
    bus.probe[31:0] = $urandom & 32'h7FFFFFFF;
    for (int i = 0; i < 4; i++) step();
    nvec++; if (hex_all !== all_f) begin nerr++; $display("FAIL freeze single reload hex: got %h want %h", hex_all, all_f); end
    bus.freeze = 0;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    bus.key_next_n = 1;
    do_reset();
    bus.auto_scan = 1;
    for (int i = 1; i <= 7; i++) begin
      bus.key_next_n = i < 6;
      step();
    end
    bus.key_next_n = 1;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      step();
      if (first < 0 && bus.ch_sel !== 4'd0) first = i;
      nvec++; if (bus.press_pulse !== 1'b0) begin nerr++; $display("FAIL rstmid press_pulse @%0d: got %b want 0", i, bus.press_pulse); end
      nvec++; if (bus.ch_sel !== 4'(m_ch)) begin nerr++; $display("FAIL rstmid ch_sel @%0d: got %0d want %0d", i, bus.ch_sel, m_ch); end
    end
    nvec++; if (first != 10) begin nerr++; $display("FAIL rstmid first advance: got %0d want 10", first); end
    bus.auto_scan = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) bus.key_next_n = ~bus.key_next_n;
      if ($urandom_range(0, 19) == 0) bus.freeze = ~bus.freeze;
      if ($urandom_range(0, 29) == 0) bus.auto_scan = ~bus.auto_scan;
      if ($urandom_range(0, 3) == 0) bus.probe[32*$urandom_range(0, N-1) +: 32] = $urandom;
      rst = $urandom_range(0, 199) == 0;
      step();
      nvec++; if (bus.ch_sel !== 4'(m_ch)) begin nerr++; $display("FAIL random ch_sel @%0d: got %0d want %0d", i, bus.ch_sel, m_ch); end
      nvec++; if (bus.press_pulse !== m_press) begin nerr++; $display("FAIL random press_pulse @%0d: got %b want %b", i, bus.press_pulse, m_press); end
      nvec++; if (hex_all !== m_hex) begin nerr++; $display("FAIL random hex @%0d: got %h want %h", i, hex_all, m_hex); end
    end
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_auto_scan();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
